// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 set-2 scan-code parser driving a two-player key bitmap and a press/release event queue
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   rx_byte    scan-code byte from the PS/2 receiver
//   rx_valid   one-cycle strobe qualifying rx_byte
//   key_state  held-key bitmap: [4:0] P1 up/left/down/right/fire, [9:5] P2 same order
//   evt_valid  event queue non-empty
//   evt_code   head event key index (0-9), 0 when empty
//   evt_make   head event kind, 1 = press, 0 = release
//   evt_ready  consumer pops the head when evt_valid & evt_ready
//   ovf        sticky flag, an event was dropped on a full queue
//   ovf_clr    clears ovf (a same-cycle overflow wins)
//
// Parameters:
//   TIMEOUT     cycles without rx_valid after which a pending prefix is abandoned
//   FIFO_DEPTH  event queue depth, power of two in 2..16
//
// Build option:
//   PS2_EXT_KEYS_EN  defined   -> P2 directions are the E0-prefixed arrow keys
//                    undefined -> P2 directions are I/J/K/L and every E0 code is ignored
module ps2_key_ctrl #(
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [9:0] key_state,
    output logic       evt_valid,
    output logic [3:0] evt_code,
    output logic       evt_make,
    input  logic       evt_ready,
    output logic       ovf,
    input  logic       ovf_clr
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);

    logic [1:0]    state, state_nx;
    logic [15:0]   tmo_cnt;
    logic          dec_en, dec_ext, dec_make;
    logic          base_hit, p2_hit, hit;
    logic [3:0]    base_idx, p2_idx, idx;
    logic          push, pop, full, accept;
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Prefix parser. A byte is decoded whenever it completes a sequence,
    // i.e. the FSM lands back in IDLE on it. E0 never completes a sequence:
    // in BRK/EXT_BRK it is a malformed prefix and is simply dropped.
    always_comb begin
        state_nx = state;
        if (rx_valid) begin
            case (state)
                IDLE:    state_nx = (rx_byte == 8'hE0) ? EXT : (rx_byte == 8'hF0) ? BRK : IDLE;
                EXT:     state_nx = (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TIMEOUT - 16'd1) begin
            state_nx = IDLE;
        end
    end

    assign dec_en   = rx_valid && state_nx == IDLE && rx_byte != 8'hE0;
    assign dec_ext  = state == EXT || state == EXT_BRK;
    assign dec_make = state == IDLE || state == EXT;

    // Keys common to both builds; only reachable without the E0 prefix.
    always_comb begin
        base_hit = !dec_ext;
        base_idx = 4'd0;
        case (rx_byte)
            8'h1D:   base_idx = 4'd0;
            8'h1C:   base_idx = 4'd1;
            8'h1B:   base_idx = 4'd2;
            8'h23:   base_idx = 4'd3;
            8'h29:   base_idx = 4'd4;
            8'h5A:   base_idx = 4'd9;
            default: base_hit = 1'b0;
        endcase
    end

`ifdef PS2_EXT_KEYS_EN
    // P2 directions on the extended arrow keys.
    always_comb begin
        p2_hit = dec_ext;
        p2_idx = 4'd5;
        case (rx_byte)
            8'h75:   p2_idx = 4'd5;
            8'h6B:   p2_idx = 4'd6;
            8'h72:   p2_idx = 4'd7;
            8'h74:   p2_idx = 4'd8;
            default: p2_hit = 1'b0;
        endcase
    end
`else
    // P2 directions on I/J/K/L; extended codes stay unmapped.
    always_comb begin
        p2_hit = !dec_ext;
        p2_idx = 4'd5;
        case (rx_byte)
            8'h43:   p2_idx = 4'd5;
            8'h3B:   p2_idx = 4'd6;
            8'h42:   p2_idx = 4'd7;
            8'h4B:   p2_idx = 4'd8;
            default: p2_hit = 1'b0;
        endcase
    end
`endif

    assign hit = base_hit || p2_hit;
    assign idx = base_hit ? base_idx : p2_idx;

    // Only real state changes become events, so typematic repeats and
    // releases of keys that are not held stay silent.
    assign push   = dec_en && hit && key_state[idx] != dec_make;
    assign full   = count == FULL;
    assign pop    = evt_valid && evt_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            key_state <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= (rx_valid || state_nx == IDLE) ? '0 : tmo_cnt + 16'd1;
            if (push)
                key_state[idx] <= dec_make;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
            ovf   <= (push && !accept) || (ovf && !ovf_clr);
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {idx, dec_make};
    end

    assign evt_valid = count != '0;
    assign evt_code  = evt_valid ? mem[rd_ptr][4:1] : 4'd0;
    assign evt_make  = evt_valid && mem[rd_ptr][0];
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed stimulus with a behavioural scoreboard for ps2_key_ctrl
module tb_ps2_key_ctrl;
    localparam int TO    = 20;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [9:0] key_state;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       evt_make;
    logic       evt_ready;
    logic       ovf;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    ps2_key_ctrl #(.TIMEOUT(16'(TO)), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .key_state(key_state), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_make(evt_make), .evt_ready(evt_ready), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Key lookup written as a table search rather than a decoder.
    function automatic int key_of(input bit ext, input logic [7:0] b);
        logic [7:0] codes [10];
        bit         extk  [10];
        codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h5A};
        extk  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef PS2_EXT_KEYS_EN
        codes[5] = 8'h75; codes[6] = 8'h6B; codes[7] = 8'h72; codes[8] = 8'h74;
        extk[5] = 1; extk[6] = 1; extk[7] = 1; extk[8] = 1;
`endif
        for (int i = 0; i < 10; i++)
            if (codes[i] == b && extk[i] == ext)
                return i;
        return -1;
    endfunction

    // Behavioural model: pending-prefix flags, idle counter, key array, event queue.
    bit         seen_e0, seen_f0, movf, m_pop, m_set;
    int         idle_cnt, m_k;
    logic [9:0] mkeys;
    logic [4:0] mq [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_e0 = 0; seen_f0 = 0; idle_cnt = 0; mkeys = '0; movf = 0;
            mq.delete();
        end else begin
            m_pop = mq.size() != 0 && evt_ready;
            m_set = 0;
            if (m_pop)
                void'(mq.pop_front());
            if (rx_valid) begin
                idle_cnt = 0;
                if (!seen_e0 && !seen_f0 && rx_byte == 8'hE0) begin
                    seen_e0 = 1;
                end else if (!seen_f0 && rx_byte == 8'hF0) begin
                    seen_f0 = 1;
                end else begin
                    m_k = (rx_byte == 8'hE0) ? -1 : key_of(seen_e0, rx_byte);
                    if (m_k >= 0 && mkeys[m_k] != !seen_f0) begin
                        mkeys[m_k] = !seen_f0;
                        if (mq.size() < DEPTH)
                            mq.push_back({4'(m_k), !seen_f0});
                        else
                            m_set = 1;
                    end
                    seen_e0 = 0; seen_f0 = 0;
                end
            end else if (seen_e0 || seen_f0) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    seen_e0 = 0; seen_f0 = 0; idle_cnt = 0;
                end
            end
            movf = m_set ? 1'b1 : (ovf_clr ? 1'b0 : movf);
        end
    end

    always @(negedge clk) begin
        chk("key_state", 16'(key_state), 16'(mkeys));
        chk("evt_valid", 16'(evt_valid), 16'(mq.size() != 0));
        chk("ovf", 16'(ovf), 16'(movf));
        if (mq.size() != 0) begin
            chk("evt_code", 16'(evt_code), 16'(mq[0][4:1]));
            chk("evt_make", 16'(evt_make), 16'(mq[0][0]));
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_byte = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
        idle(3);
        chk("rst_keys", 16'(key_state), 16'h000);
        chk("rst_head", 16'({evt_valid, evt_code, evt_make}), 16'h00);
        chk("rst_ovf", 16'(ovf), 16'h0);
        rst = 1'b1;

        // make, typematic repeat, break of W
        send(8'h1D);
        chk("w_make_keys", 16'(key_state), 16'h001);
        send(8'h1D);
        send(8'hF0); send(8'h1D);
        chk("w_brk_keys", 16'(key_state), 16'h000);
        chk("w_evt1", 16'({evt_valid, evt_code, evt_make}), 16'b1_0000_1);
        pop_one();
        chk("w_evt2", 16'({evt_valid, evt_code, evt_make}), 16'b1_0000_0);
        pop_one();
        chk("w_empty", 16'(evt_valid), 16'h0);

        // extended arrow press/release
        send(8'hE0); send(8'h75);
`ifdef PS2_EXT_KEYS_EN
        chk("ext_make_keys", 16'(key_state), 16'h020);
`else
        chk("ext_make_keys", 16'(key_state), 16'h000);
`endif
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_brk_keys", 16'(key_state), 16'h000);
`ifdef PS2_EXT_KEYS_EN
        chk("ext_evt1", 16'({evt_valid, evt_code, evt_make}), 16'b1_0101_1);
        pop_one();
        chk("ext_evt2", 16'({evt_valid, evt_code, evt_make}), 16'b1_0101_0);
        pop_one();
`else
        chk("ext_no_evt", 16'(evt_valid), 16'h0);
`endif

        // J key is P2 left only in the default build
        send(8'h3B);
`ifdef PS2_EXT_KEYS_EN
        chk("j_keys", 16'(key_state), 16'h000);
`else
        chk("j_keys", 16'(key_state), 16'h040);
`endif
        send(8'hF0); send(8'h3B);
        evt_ready = 1'b1;
        idle(3);

        // prefix timeout boundary: one cycle short is still a break
        send(8'hF0); idle(TO - 2); send(8'h1C);
        chk("tmo_short_keys", 16'(key_state), 16'h000);
        send(8'hF0); idle(TO - 1); send(8'h1C);
        chk("tmo_keys", 16'(key_state), 16'h002);
        chk("tmo_evt", 16'({evt_valid, evt_code, evt_make}), 16'b1_0001_1);
        send(8'hF0); send(8'h1C);

        // E0 after F0 is dropped; next byte parsed from IDLE as a make
        send(8'h1B); send(8'hF0); send(8'hE0); send(8'h1B);
        chk("e0_in_brk_keys", 16'(key_state), 16'h004);
        send(8'hF0); send(8'h1B);
        idle(3);

        // overflow with five makes on a depth-4 queue
        evt_ready = 1'b0;
        send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'h29);
        chk("ovf_keys", 16'(key_state), 16'h01F);
        chk("ovf_set", 16'(ovf), 16'h1);
        chk("ovf_head", 16'({evt_valid, evt_code, evt_make}), 16'b1_0000_1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("ovf_clr", 16'(ovf), 16'h0);

        // clear coinciding with a new overflow keeps the flag
        @(posedge clk); #1 rx_byte = 8'h5A; rx_valid = 1'b1; ovf_clr = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0; ovf_clr = 1'b0;
        chk("ovf_clr_race", 16'(ovf), 16'h1);
        chk("ovf_race_keys", 16'(key_state), 16'h21F);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;

        // push and pop together on a full queue
        send(8'hF0);
        @(posedge clk); #1 rx_byte = 8'h1D; rx_valid = 1'b1; evt_ready = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0; evt_ready = 1'b0;
        chk("full_pp_ovf", 16'(ovf), 16'h0);
        chk("full_pp_head", 16'({evt_valid, evt_code, evt_make}), 16'b1_0001_1);
        chk("full_pp_keys", 16'(key_state), 16'h21E);
        evt_ready = 1'b1;
        idle(6);
        chk("drained", 16'(evt_valid), 16'h0);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1B); send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h5A);
        idle(3);

        // reset in the middle of a break sequence
        evt_ready = 1'b0;
        send(8'hF0);
        #3 rst = 1'b0;
        idle(2);
        rst = 1'b1;
        send(8'h23);
        chk("rst_mid_keys", 16'(key_state), 16'h008);
        chk("rst_mid_evt", 16'({evt_valid, evt_code, evt_make}), 16'b1_0011_1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
